// File: rtl/census_transform_5x5_pkg.sv
// Shared definitions for the census transform and the Hamming cost stage:
// image defaults, window geometry, FSM encoding and the census bit map.
package census_transform_5x5_pkg;

  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;
  localparam int PIX_W_DEF  = 8;
  localparam int CODE_W_DEF = 32;
  localparam int WIN        = 5;
  localparam int WIN_TAPS   = WIN * WIN;
  localparam int CENTRE     = WIN_TAPS / 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Row-major window position p (centre excluded) -> census code bit index.
  function automatic int census_bit_idx(input int p);
    return 23 - (p - ((p > CENTRE) ? 1 : 0));
  endfunction

endpackage

// File: rtl/census_transform_5x5_if.sv
// Pixel-in / census-out bundle of the 5x5 census transform, plus FSM debug state.
interface census_transform_5x5_if
  import census_transform_5x5_pkg::*;
  #(parameter int PIX_W = PIX_W_DEF, parameter int CODE_W = CODE_W_DEF);

  // in_valid marks a pixel this cycle and is never stalled (no ready);
  // census_valid marks a code and its sof/eol markers for exactly one cycle.
  logic              in_valid;
  logic              in_sof;
  logic [PIX_W-1:0]  in_pix;
  logic              census_valid;
  logic [CODE_W-1:0] census;
  logic              census_sof;
  logic              census_eol;
  logic              frame_done;
  state_t            state;

  modport master (
    output in_valid, in_sof, in_pix,
    input  census_valid, census, census_sof, census_eol, frame_done, state
  );

  modport slave (
    input  in_valid, in_sof, in_pix,
    output census_valid, census, census_sof, census_eol, frame_done, state
  );

endinterface

// File: rtl/census_line_buffer.sv
// One-line delay: combinational read of the previous line at addr, then the
// new pixel is written to the same address on an enabled edge.
module census_line_buffer
  import census_transform_5x5_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

endmodule

// File: rtl/census_transform_5x5.sv
// Streaming 5x5 census transform: frame FSM, raster counters, four chained line
// buffers feeding a 5x5 window, 24 comparators and registered outputs.
module census_transform_5x5
  import census_transform_5x5_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int CODE_W = CODE_W_DEF
) (
  input logic              clk,
  input logic              rst,
  census_transform_5x5_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(WIN - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(WIN - 1);

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [CW-1:0]     eff_col;
  logic [RW-1:0]     eff_row;
  logic              accept, last_col, last_pix, emit;
  logic              pend, pend_sof, pend_eol;
  logic [CODE_W-1:0] code;
  logic [PIX_W-1:0]  lb_in  [4];
  logic [PIX_W-1:0]  lb_out [4];
  logic [PIX_W-1:0]  win    [WIN][WIN];

  // An sof pixel always lands at (0,0), whether it opens or abandons a frame.
  assign accept   = bus.in_valid && (bus.in_sof || state == ST_ACTIVE);
  assign eff_col  = bus.in_sof ? '0 : col;
  assign eff_row  = bus.in_sof ? '0 : row;
  assign last_col = (eff_col == COL_LAST);
  assign last_pix = last_col && (eff_row == ROW_LAST);
  assign emit     = accept && (eff_row >= ROW_MIN) && (eff_col >= COL_MIN);
  assign bus.state = state;

  assign lb_in[0] = bus.in_pix;
  for (genvar k = 0; k < 4; k++) begin : g_lb
    if (k > 0) begin : g_chain
      assign lb_in[k] = lb_out[k-1];
    end
    census_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(CW)) u_lb (
      .clk  (clk),
      .en   (accept),
      .addr (eff_col),
      .din  (lb_in[k]),
      .dout (lb_out[k])
    );
  end

  // Row 4 / tap 4 hold the newest pixel; lb_out[k] is the pixel k+1 lines above.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int wr = 0; wr < WIN; wr++) begin
        for (int wc = 0; wc < WIN - 1; wc++) win[wr][wc] <= win[wr][wc+1];
      end
      for (int wr = 0; wr < WIN - 1; wr++) win[wr][WIN-1] <= lb_out[WIN-2-wr];
      win[WIN-1][WIN-1] <= bus.in_pix;
    end
  end

  always_comb begin
    code = '0;
    for (int p = 0; p < WIN_TAPS; p++) begin
      if (p != CENTRE && win[p / WIN][p % WIN] < win[WIN/2][WIN/2])
        code[census_bit_idx(p)] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      col              <= '0;
      row              <= '0;
      pend             <= 1'b0;
      pend_sof         <= 1'b0;
      pend_eol         <= 1'b0;
      bus.census_valid <= 1'b0;
      bus.census       <= '0;
      bus.census_sof   <= 1'b0;
      bus.census_eol   <= 1'b0;
      bus.frame_done   <= 1'b0;
    end else begin
      bus.frame_done   <= 1'b0;
      bus.census_valid <= pend;
      bus.census_sof   <= pend && pend_sof;
      bus.census_eol   <= pend && pend_eol;
      if (pend) bus.census <= code;
      pend     <= emit;
      pend_sof <= (eff_row == ROW_MIN) && (eff_col == COL_MIN);
      pend_eol <= last_col;
      if (accept) begin
        if (last_pix) begin
          state          <= ST_IDLE;
          col            <= '0;
          row            <= '0;
          bus.frame_done <= 1'b1;
        end else begin
          state <= ST_ACTIVE;
          if (last_col) begin
            col <= '0;
            row <= eff_row + 1'b1;
          end else begin
            col <= eff_col + 1'b1;
            row <= eff_row;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_census_transform_5x5.sv
// Bench for census_transform_5x5 on a 16x8 image against a window-level
// reference model computed straight from image coordinates.
module tb_census_transform_5x5;
  import census_transform_5x5_pkg::*;

  localparam int W = 16;
  localparam int H = 8;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  census_transform_5x5_if #(.PIX_W(8), .CODE_W(32)) bus ();

  census_transform_5x5 #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .CODE_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  img [H][W];
  logic [33:0] exp_q [$];
  logic [33:0] got_q [$];
  logic [33:0] g;
  int fd_cnt = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  // ---------------- capture ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.census_valid) got_q.push_back({bus.census_sof, bus.census_eol, bus.census});
      if (bus.frame_done) fd_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus / model ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
    end
  endtask

  task automatic drive_pix(input logic sof, input logic [7:0] pix);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_pix   = pix;
  endtask

  task automatic drive_frame(input int n_pix, input int gap_pct);
    for (int i = 0; i < n_pix; i++) begin
      while ($urandom_range(99) < gap_pct) idle(1);
      drive_pix(i == 0, img[i / W][i % W]);
    end
  endtask

  task automatic fill(input int kind, input int maxv);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        case (kind)
          0: img[r][c] = 8'h80;
          1: img[r][c] = 8'(c * 8);
          2: img[r][c] = 8'(r * 16);
          default: img[r][c] = 8'($urandom_range(maxv));
        endcase
  endtask

  // Expected codes for the first n_pix pixels of the current image.
  task automatic model_frame(input int n_pix);
    logic [31:0] code;
    int p;
    for (int r = 4; r < H; r++)
      for (int c = 4; c < W; c++)
        if (r * W + c < n_pix) begin
          code = '0;
          for (int dr = -2; dr <= 2; dr++)
            for (int dc = -2; dc <= 2; dc++) begin
              p = (dr + 2) * 5 + (dc + 2);
              if (p != 12 && img[r-2+dr][c-2+dc] < img[r-2][c-2])
                code[23 - (p > 12 ? p - 1 : p)] = 1'b1;
            end
          exp_q.push_back({(r == 4 && c == 4), (c == W - 1), code});
        end
  endtask

  task automatic start_test();
    exp_q.delete();
    got_q.delete();
    fd_cnt = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    total_cnt++; if (bus.census_valid !== 1'b0) $display("FAIL reset census_valid: got %b expected 0", bus.census_valid); else pass_cnt++;
    total_cnt++; if (bus.census !== 32'h0) $display("FAIL reset census: got %h expected 0", bus.census); else pass_cnt++;
    total_cnt++; if (bus.census_sof !== 1'b0) $display("FAIL reset census_sof: got %b expected 0", bus.census_sof); else pass_cnt++;
    total_cnt++; if (bus.census_eol !== 1'b0) $display("FAIL reset census_eol: got %b expected 0", bus.census_eol); else pass_cnt++;
    total_cnt++; if (bus.frame_done !== 1'b0) $display("FAIL reset frame_done: got %b expected 0", bus.frame_done); else pass_cnt++;
    total_cnt++; if (bus.state !== ST_IDLE) $display("FAIL reset state: got %0d expected %0d", bus.state, ST_IDLE); else pass_cnt++;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_constant(input int gap_pct);
    start_test();
    fill(0, 0);
    model_frame(NPIX);
    drive_frame(NPIX, gap_pct);
    idle(4);
    total_cnt++; if (got_q.size() != 48) $display("FAIL const count (gap %0d): got %0d expected 48", gap_pct, got_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++; g = (i < got_q.size()) ? got_q[i] : 'x;
      if (g !== exp_q[i]) $display("FAIL const code %0d (gap %0d): got %h expected %h", i, gap_pct, g, exp_q[i]); else pass_cnt++;
    end
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    total_cnt++; if (g !== {2'b10, 32'h0}) $display("FAIL const first: got %h expected %h", g, {2'b10, 32'h0}); else pass_cnt++;
    total_cnt++; if (fd_cnt != 1) $display("FAIL const frame_done: got %0d expected 1", fd_cnt); else pass_cnt++;
  endtask

  task automatic test_ramps();
    for (int kind = 1; kind <= 2; kind++) begin
      start_test();
      fill(kind, 0);
      model_frame(NPIX);
      drive_frame(NPIX, 0);
      idle(4);
      total_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL ramp%0d count: got %0d expected %0d", kind, got_q.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
        total_cnt++; g = (i < got_q.size()) ? got_q[i] : 'x;
        if (g !== exp_q[i]) $display("FAIL ramp%0d code %0d: got %h expected %h", kind, i, g, exp_q[i]); else pass_cnt++;
      end
      g = (got_q.size() > 5) ? got_q[5] : 'x;
      total_cnt++;
      if (g[31:0] !== (kind == 1 ? 32'h00C63318 : 32'h00FFC000))
        $display("FAIL ramp%0d literal: got %h expected %h", kind, g[31:0], (kind == 1 ? 32'h00C63318 : 32'h00FFC000));
      else pass_cnt++;
      total_cnt++; if (fd_cnt != 1) $display("FAIL ramp%0d frame_done: got %0d expected 1", kind, fd_cnt); else pass_cnt++;
    end
  endtask

  task automatic test_random_gaps();
    start_test();
    fill(3, 3);
    model_frame(NPIX);
    drive_frame(NPIX, 30);
    idle(4);
    total_cnt++; if (got_q.size() != exp_q.size()) $display("FAIL random count: got %0d expected %0d", got_q.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++; g = (i < got_q.size()) ? got_q[i] : 'x;
      if (g !== exp_q[i]) $display("FAIL random code %0d: got %h expected %h", i, g, exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (fd_cnt != 1) $display("FAIL random frame_done: got %0d expected 1", fd_cnt); else pass_cnt++;
  endtask

  task automatic test_abandon();
    start_test();
    fill(1, 0);
    model_frame(5 * W + 3);
    model_frame(NPIX);
    drive_frame(5 * W + 3, 0);
    drive_frame(NPIX, 0);
    idle(4);
    total_cnt++; if (got_q.size() != 60) $display("FAIL abandon count: got %0d expected 60", got_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++; g = (i < got_q.size()) ? got_q[i] : 'x;
      if (g !== exp_q[i]) $display("FAIL abandon code %0d: got %h expected %h", i, g, exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (fd_cnt != 1) $display("FAIL abandon frame_done: got %0d expected 1", fd_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    start_test();
    fill(2, 0);
    drive_frame(6 * W + 8, 0);
    drive_pix(1'b0, img[6][8]);
    @(posedge clk); #2;
    total_cnt++; if (bus.census_valid !== 1'b1) $display("FAIL rstmid pre valid: got %b expected 1", bus.census_valid); else pass_cnt++;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    total_cnt++; if (bus.census_valid !== 1'b0) $display("FAIL rstmid census_valid: got %b expected 0", bus.census_valid); else pass_cnt++;
    total_cnt++; if (bus.census !== 32'h0) $display("FAIL rstmid census: got %h expected 0", bus.census); else pass_cnt++;
    total_cnt++; if (bus.state !== ST_IDLE) $display("FAIL rstmid state: got %0d expected %0d", bus.state, ST_IDLE); else pass_cnt++;
    idle(2);
    rst = 1'b0;
    start_test();
    for (int i = 0; i < 20; i++) drive_pix(1'b0, 8'($urandom_range(255)));
    idle(4);
    total_cnt++; if (got_q.size() != 0) $display("FAIL rstmid no-sof codes: got %0d expected 0", got_q.size()); else pass_cnt++;
    total_cnt++; if (fd_cnt != 0) $display("FAIL rstmid no-sof frame_done: got %0d expected 0", fd_cnt); else pass_cnt++;
    start_test();
    fill(3, 255);
    model_frame(NPIX);
    drive_frame(NPIX, 0);
    idle(4);
    total_cnt++; if (got_q.size() != 48) $display("FAIL rstmid count: got %0d expected 48", got_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++; g = (i < got_q.size()) ? got_q[i] : 'x;
      if (g !== exp_q[i]) $display("FAIL rstmid code %0d: got %h expected %h", i, g, exp_q[i]); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    start_test();
    fill(3, 3);
    model_frame(NPIX);
    drive_frame(NPIX, 0);
    fill(3, 7);
    model_frame(NPIX);
    drive_frame(NPIX, 0);
    idle(4);
    total_cnt++; if (got_q.size() != 96) $display("FAIL b2b count: got %0d expected 96", got_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++; g = (i < got_q.size()) ? got_q[i] : 'x;
      if (g !== exp_q[i]) $display("FAIL b2b code %0d: got %h expected %h", i, g, exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (fd_cnt != 2) $display("FAIL b2b frame_done: got %0d expected 2", fd_cnt); else pass_cnt++;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pix   = '0;
    test_reset();
    idle(2);
    test_constant(0);
    test_ramps();
    test_constant(30);
    test_random_gaps();
    test_abandon();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
